// File: rtl/di_bus_arbiter.sv
// di_bus_arbiter: two-master round-robin arbiter for the di_* register bus; define DI_ARB_TIMEOUT_EN to add the ownership watchdog
module di_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] TIMEOUT_STATUS = 16'hFFFF
) (
    input  logic        ifclk,
    input  logic        reset,
    input  logic [15:0] m0_term_addr,
    input  logic [31:0] m0_reg_addr,
    input  logic [31:0] m0_len,
    input  logic        m0_read_mode,
    input  logic        m0_read_req,
    input  logic        m0_read,
    input  logic        m0_write_mode,
    input  logic        m0_write,
    input  logic [31:0] m0_reg_datai,
    output logic        m0_read_rdy,
    output logic        m0_write_rdy,
    output logic [31:0] m0_reg_datao,
    output logic [15:0] m0_transfer_status,
    input  logic [15:0] m1_term_addr,
    input  logic [31:0] m1_reg_addr,
    input  logic [31:0] m1_len,
    input  logic        m1_read_mode,
    input  logic        m1_read_req,
    input  logic        m1_read,
    input  logic        m1_write_mode,
    input  logic        m1_write,
    input  logic [31:0] m1_reg_datai,
    output logic        m1_read_rdy,
    output logic        m1_write_rdy,
    output logic [31:0] m1_reg_datao,
    output logic [15:0] m1_transfer_status,
    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic [31:0] di_len,
    output logic [31:0] di_reg_datai,
    output logic        di_read_mode,
    output logic        di_read_req,
    output logic        di_read,
    output logic        di_write_mode,
    output logic        di_write,
    input  logic        di_read_rdy,
    input  logic        di_write_rdy,
    input  logic [31:0] di_reg_datao,
    input  logic [15:0] di_transfer_status,
    output logic [1:0]  grant,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
    state_t state, state_nxt;
    logic last, pend0, pend1, own0, own1, abort, act, req0, req1, arb0, arb1;
    assign req0 = m0_read_mode | m0_write_mode | m0_read_req;
    assign req1 = m1_read_mode | m1_write_mode | m1_read_req;
    // a captured read_req pulse keeps asking for the bus after the strobe itself has gone
    assign arb0 = req0 | pend0;
    assign arb1 = req1 | pend1;
    assign own0 = state == OWN0;
    assign own1 = state == OWN1;
    assign act  = (own0 | own1) & ~abort;
`ifdef DI_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic        timeout_q;
    assign abort   = (own0 | own1) && cnt == 16'(TIMEOUT_CYCLES - 1);
    assign timeout = timeout_q;
    // watchdog: count cycles of the current grant, latch a sticky flag when it fires
    always_ff @(posedge ifclk or posedge reset)
        if (reset) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= (own0 | own1) ? cnt + 16'd1 : '0;
            timeout_q <= timeout_q | abort;
        end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign abort      = 1'b0;
    assign timeout    = 1'b0;
`endif
    // state, round-robin pointer and read_req pulses seen while not owning the bus
    always_ff @(posedge ifclk or posedge reset)
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= own0 ? 1'b0 : own1 ? 1'b1 : last;
            pend0 <= ~own0 & (pend0 | m0_read_req);
            pend1 <= ~own1 & (pend1 | m1_read_req);
        end
    // next state: grant one cycle after the request, alternate on contention, one GAP cycle after each release
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (arb0 & arb1) ? (last ? OWN0 : OWN1) : arb0 ? OWN0 : arb1 ? OWN1 : IDLE;
            OWN0:    state_nxt = (~req0 | abort) ? GAP : OWN0;
            OWN1:    state_nxt = (~req1 | abort) ? GAP : OWN1;
            default: state_nxt = IDLE;
        endcase
    end
    assign grant         = {own1, own0};
    assign di_term_addr  = own0 ? m0_term_addr : own1 ? m1_term_addr : '0;
    assign di_reg_addr   = own0 ? m0_reg_addr  : own1 ? m1_reg_addr  : '0;
    assign di_len        = own0 ? m0_len       : own1 ? m1_len       : '0;
    assign di_reg_datai  = own0 ? m0_reg_datai : own1 ? m1_reg_datai : '0;
    assign di_read_mode  = act & (own0 ? m0_read_mode  : m1_read_mode);
    assign di_read_req   = act & (own0 ? (m0_read_req | pend0) : (m1_read_req | pend1));
    assign di_read       = act & (own0 ? m0_read       : m1_read);
    assign di_write_mode = act & (own0 ? m0_write_mode : m1_write_mode);
    assign di_write      = act & (own0 ? m0_write      : m1_write);
    assign m0_read_rdy   = own0 & (abort | di_read_rdy);
    assign m0_write_rdy  = own0 & (abort | di_write_rdy);
    assign m1_read_rdy   = own1 & (abort | di_read_rdy);
    assign m1_write_rdy  = own1 & (abort | di_write_rdy);
    assign m0_reg_datao       = (own0 & abort) ? '0 : di_reg_datao;
    assign m1_reg_datao       = (own1 & abort) ? '0 : di_reg_datao;
    assign m0_transfer_status = (own0 & abort) ? TIMEOUT_STATUS : di_transfer_status;
    assign m1_transfer_status = (own1 & abort) ? TIMEOUT_STATUS : di_transfer_status;
endmodule

// File: tb/tb_di_bus_arbiter.sv
// tb_di_bus_arbiter: scoreboard bench for di_bus_arbiter against a cycle-level ownership model
module tb_di_bus_arbiter;
`ifdef DI_ARB_TIMEOUT_EN
    localparam int TC    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TC    = 1024;
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [15:0] TS = 16'hFFFF;
    typedef struct packed {
        logic [1:0]  grant;
        logic        rrq, rd, rm, wr, wm;
        logic [15:0] ta;
        logic [31:0] ra, la, wd;
        logic [1:0]  rrdy, wrdy;
        logic [31:0] do0, do1;
        logic [15:0] st0, st1;
        logic        to;
    } exp_t;
    logic ifclk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] term_addr [2];
    logic [31:0] reg_addr [2], len [2], reg_datai [2];
    logic read_mode [2], read_req [2], read [2], write_mode [2], write [2];
    logic m0_read_rdy, m0_write_rdy, m1_read_rdy, m1_write_rdy;
    logic [31:0] m0_reg_datao, m1_reg_datao;
    logic [15:0] m0_transfer_status, m1_transfer_status;
    logic [15:0] di_term_addr, di_transfer_status;
    logic [31:0] di_reg_addr, di_len, di_reg_datai, di_reg_datao;
    logic di_read_mode, di_read_req, di_read, di_write_mode, di_write, di_read_rdy, di_write_rdy;
    logic [1:0] grant;
    logic timeout;
    exp_t q [$];
    int vectors = 0;
    int miscompares = 0;
    int owner, last_m, own_cyc;
    bit in_gap, to_m;
    bit pend [2];
    int glen [2], ggap [2], gkind [2];

    di_bus_arbiter #(.TIMEOUT_CYCLES(TC), .TIMEOUT_STATUS(TS)) dut (
        .ifclk(ifclk), .reset(reset),
        .m0_term_addr(term_addr[0]), .m0_reg_addr(reg_addr[0]), .m0_len(len[0]),
        .m0_read_mode(read_mode[0]), .m0_read_req(read_req[0]), .m0_read(read[0]),
        .m0_write_mode(write_mode[0]), .m0_write(write[0]), .m0_reg_datai(reg_datai[0]),
        .m0_read_rdy(m0_read_rdy), .m0_write_rdy(m0_write_rdy),
        .m0_reg_datao(m0_reg_datao), .m0_transfer_status(m0_transfer_status),
        .m1_term_addr(term_addr[1]), .m1_reg_addr(reg_addr[1]), .m1_len(len[1]),
        .m1_read_mode(read_mode[1]), .m1_read_req(read_req[1]), .m1_read(read[1]),
        .m1_write_mode(write_mode[1]), .m1_write(write[1]), .m1_reg_datai(reg_datai[1]),
        .m1_read_rdy(m1_read_rdy), .m1_write_rdy(m1_write_rdy),
        .m1_reg_datao(m1_reg_datao), .m1_transfer_status(m1_transfer_status),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
        .di_reg_datai(di_reg_datai), .di_read_mode(di_read_mode), .di_read_req(di_read_req),
        .di_read(di_read), .di_write_mode(di_write_mode), .di_write(di_write),
        .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
        .di_reg_datao(di_reg_datao), .di_transfer_status(di_transfer_status),
        .grant(grant), .timeout(timeout)
    );

    always #5 ifclk = ~ifclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
    endtask

    // each master runs read, write or bare read_req transactions separated by idle cycles
    task automatic gen();
        for (int i = 0; i < 2; i++) begin
            bit first;
            first = 1'b0;
            if (glen[i] == 0 && ggap[i] == 0) begin
                gkind[i] = int'($urandom_range(0, 2));
                glen[i]  = gkind[i] == 2 ? 1 : int'($urandom_range(1, 8));
                ggap[i]  = int'($urandom_range(1, 4));
                first    = 1'b1;
            end
            term_addr[i] = 16'($urandom);
            reg_addr[i]  = $urandom;
            len[i]       = $urandom;
            reg_datai[i] = $urandom;
            if (glen[i] > 0) begin
                read_mode[i]  = gkind[i] == 0;
                write_mode[i] = gkind[i] == 1;
                read_req[i]   = first ? gkind[i] != 1 : (gkind[i] == 0 && $urandom_range(0, 7) == 0);
                read[i]       = gkind[i] == 0 && $urandom_range(0, 1) == 1;
                write[i]      = gkind[i] == 1 && $urandom_range(0, 1) == 1;
                glen[i]--;
            end else begin
                read_mode[i] = 1'b0; write_mode[i] = 1'b0; read_req[i] = 1'b0;
                read[i] = 1'b0; write[i] = 1'b0;
                ggap[i]--;
            end
        end
        di_read_rdy        = 1'($urandom);
        di_write_rdy       = 1'($urandom);
        di_reg_datao       = $urandom;
        di_transfer_status = 16'($urandom);
    endtask

    // predict this cycle's outputs from the ownership model, queue them, then advance the model one clock
    task automatic tick(input bit rnd);
        exp_t e;
        bit ab, act;
        bit r [2];
        int o;
        if (rnd) gen();
        if (reset) begin
            owner = -1; in_gap = 1'b0; last_m = 1; pend = '{1'b0, 1'b0}; own_cyc = 0; to_m = 1'b0;
        end
        o   = owner;
        ab  = TO_EN && o >= 0 && own_cyc == TC - 1;
        act = o >= 0 && !ab;
        e = '0;
        e.do0 = di_reg_datao;
        e.do1 = di_reg_datao;
        e.st0 = di_transfer_status;
        e.st1 = di_transfer_status;
        e.to  = to_m;
        if (o >= 0) begin
            e.grant = o == 0 ? 2'b01 : 2'b10;
            e.ta  = term_addr[o];
            e.ra  = reg_addr[o];
            e.la  = len[o];
            e.wd  = reg_datai[o];
            e.rm  = act && read_mode[o];
            e.rrq = act && (read_req[o] || pend[o]);
            e.rd  = act && read[o];
            e.wm  = act && write_mode[o];
            e.wr  = act && write[o];
            e.rrdy[o] = ab || di_read_rdy;
            e.wrdy[o] = ab || di_write_rdy;
            if (ab && o == 0) begin e.do0 = '0; e.st0 = TS; end
            if (ab && o == 1) begin e.do1 = '0; e.st1 = TS; end
        end
        q.push_back(e);
        if (!reset) begin
            for (int i = 0; i < 2; i++) r[i] = read_mode[i] || write_mode[i] || read_req[i] || pend[i];
            if (in_gap) in_gap = 1'b0;
            else if (o < 0) begin
                if (r[0] && r[1]) owner = last_m == 1 ? 0 : 1;
                else if (r[0]) owner = 0;
                else if (r[1]) owner = 1;
                own_cyc = 0;
            end else begin
                last_m = o;
                own_cyc++;
                if (!(read_mode[o] || write_mode[o] || read_req[o]) || ab) begin
                    owner = -1; in_gap = 1'b1; to_m = to_m || ab;
                end
            end
            for (int i = 0; i < 2; i++) pend[i] = (o != i) && (pend[i] || read_req[i]);
        end
        @(posedge ifclk);
        #1;
    endtask

    always @(negedge ifclk) begin
        exp_t a, e;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {grant, di_read_req, di_read, di_read_mode, di_write, di_write_mode,
                 di_term_addr, di_reg_addr, di_len, di_reg_datai,
                 {m1_read_rdy, m0_read_rdy}, {m1_write_rdy, m0_write_rdy},
                 m0_reg_datao, m1_reg_datao, m0_transfer_status, m1_transfer_status, timeout};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL scoreboard vec %0d: dut=%h model=%h", vectors, a, e);
            end
        end
    end

    initial begin
        int oc [2];
        int starts;
        logic [1:0] expg, pg;
        for (int i = 0; i < 2; i++) begin
            term_addr[i] = '0; reg_addr[i] = '0; len[i] = '0; reg_datai[i] = '0;
            read_mode[i] = 1'b0; read_req[i] = 1'b0; read[i] = 1'b0;
            write_mode[i] = 1'b0; write[i] = 1'b0;
            glen[i] = 0; ggap[i] = 0; gkind[i] = 0;
        end
        di_read_rdy = 1'b1; di_write_rdy = 1'b1; di_reg_datao = '0; di_transfer_status = '0;
        @(posedge ifclk);
        #1;
        tick(0);
        tick(0);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rdy", {m1_read_rdy, m0_read_rdy, m1_write_rdy, m0_write_rdy}, 0);
        chk("rst_modes", {di_read_mode, di_write_mode, di_read_req, di_read, di_write}, 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b0;
        // m0 read alone
        read_mode[0] = 1'b1; read_req[0] = 1'b1; term_addr[0] = 16'h00A5;
        #1 chk("m0_c0_grant", 32'(grant), 0);
        tick(0);
        read_req[0] = 1'b0; di_reg_datao = 32'h1234_5678;
        #1;
        chk("m0_grant", 32'(grant), 1);
        chk("m0_pend_read_req", 32'(di_read_req), 1);
        chk("m0_datao", m0_reg_datao, 32'h1234_5678);
        chk("m0_term_addr", 32'(di_term_addr), 32'h00A5);
        tick(0);
        read_mode[0] = 1'b0;
        repeat (3) tick(0);
        // contention and isolation, starting from a fresh reset
        reset = 1'b1;
        tick(0);
        reset = 1'b0;
        read_mode[0] = 1'b1; write_mode[1] = 1'b1; write[1] = 1'b1; write[0] = 1'b0; di_write_rdy = 1'b1;
        #1 chk("ct_c0_grant", 32'(grant), 0);
        tick(0);
        #1;
        chk("ct_own0", 32'(grant), 1);
        chk("iso_di_write", 32'(di_write), 0);
        chk("iso_m1_wrdy", 32'(m1_write_rdy), 0);
        chk("iso_m0_wrdy", 32'(m0_write_rdy), 1);
        tick(0);
        read_mode[0] = 1'b0;
        #1 chk("ct_release", 32'(grant), 1);
        tick(0);
        #1 chk("ct_gap", {30'd0, grant}, 0);
        chk("ct_gap_wmode", 32'(di_write_mode), 0);
        tick(0);
        #1 chk("ct_idle", 32'(grant), 0);
        tick(0);
        #1 chk("ct_own1", 32'(grant), 2);
        chk("ct_m1_wrdy", 32'(m1_write_rdy), 1);
        tick(0);
        write_mode[1] = 1'b0; write[1] = 1'b0;
        repeat (3) tick(0);
        // fairness: both keep requesting, each owner releases after three cycles
        oc = '{0, 0}; starts = 0; expg = 2'b01; pg = 2'b00;
        for (int c = 0; c < 200 && starts < 8; c++) begin
            for (int i = 0; i < 2; i++) begin
                read_mode[i] = !(grant[i] && oc[i] >= 2);
                oc[i] = grant[i] ? oc[i] + 1 : 0;
            end
            #1;
            if (grant != 2'b00 && pg == 2'b00) begin
                chk("fair_grant", 32'(grant), 32'(expg));
                expg = {expg[0], expg[1]};
                starts++;
            end
            pg = grant;
            tick(0);
        end
        chk("fair_count", starts, 8);
        read_mode[0] = 1'b0; read_mode[1] = 1'b0;
        repeat (3) tick(0);
        // long hold with a silent slave: aborted by the watchdog only when it is built in
        di_read_rdy = 1'b0; di_transfer_status = 16'h0042; read_mode[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 15) chk("to_pre_rdy", 32'(m0_read_rdy), 0);
            if (c == 16) begin
                chk("to_rdy", 32'(m0_read_rdy), 32'(TO_EN));
                chk("to_status", 32'(m0_transfer_status), TO_EN ? 32'hFFFF : 32'h0042);
                chk("to_mode", 32'(di_read_mode), 32'(!TO_EN));
            end
            if (c == 17) begin
                chk("to_grant", 32'(grant), TO_EN ? 0 : 1);
                chk("to_flag", 32'(timeout), 32'(TO_EN));
            end
            tick(0);
        end
        read_mode[0] = 1'b0;
        repeat (3) tick(0);
        // reset in the middle of an m1 write
        write_mode[1] = 1'b1;
        tick(0);
        #1 chk("rst_pre_grant", 32'(grant), 2);
        @(negedge ifclk);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_grant", 32'(grant), 0);
        chk("rst_async_wmode", 32'(di_write_mode), 0);
        @(posedge ifclk);
        #1;
        tick(0);
        reset = 1'b0;
        #1 chk("rst_idle_grant", 32'(grant), 0);
        tick(0);
        #1 chk("rst_rearb", 32'(grant), 2);
        repeat (2000) tick(1);
        @(negedge ifclk);
        #1 chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
